// File: rtl/jtag_reg_master_if.sv
// Signal bundle between the JTAG debug module, the register master and the core register file.
interface jtag_reg_master_if;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 32;

   // command from the debug module
   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic              cmd_write_i;
   logic [ADDR_W-1:0] cmd_addr_i;
   logic [DATA_W-1:0] cmd_wdata_i;

   // response to the debug module
   logic              resp_valid_o;
   logic              resp_ready_i;
   logic [DATA_W-1:0] resp_rdata_o;
   logic              resp_err_o;

   // core halt handshake
   logic              halt_req_o;
   logic              halted_i;

   // register-file debug port
   logic              reg_we_o;
   logic [ADDR_W-1:0] reg_addr_o;
   logic [DATA_W-1:0] reg_wdata_o;
   logic [DATA_W-1:0] reg_rdata_i;

   modport master (
      input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
      input  resp_ready_i, halted_i, reg_rdata_i,
      output cmd_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      output halt_req_o, reg_we_o, reg_addr_o, reg_wdata_o
   );

   modport slave (
      output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
      output resp_ready_i, halted_i, reg_rdata_i,
      input  cmd_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      input  halt_req_o, reg_we_o, reg_addr_o, reg_wdata_o
   );
endinterface

// File: rtl/jtag_reg_master.sv
// jtag_reg_master: executes one abstract register read/write from the JTAG debug module
// against the core register file while the core is held halted.
module jtag_reg_master #(
   parameter int unsigned HALT_TIMEOUT = 255,
   parameter bit          VERIFY_WR    = 1'b1
) (
   input logic               clk,
   input logic               rst,
   jtag_reg_master_if.master bus
);

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      WRITE,
      VERIFY,
      READ,
      RESP
   } state_t;

   state_t            state;
   logic              wr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt;

   // Command sequencer; every output is registered and updated on the edge that enters its state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         wr_q             <= 1'b0;
         wdata_q          <= '0;
         cnt              <= '0;
         bus.cmd_ready_o  <= 1'b0;
         bus.resp_valid_o <= 1'b0;
         bus.resp_rdata_o <= '0;
         bus.resp_err_o   <= 1'b0;
         bus.halt_req_o   <= 1'b0;
         bus.reg_we_o     <= 1'b0;
         bus.reg_addr_o   <= '0;
         bus.reg_wdata_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.cmd_ready_o <= 1'b1;
               if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                  wr_q            <= bus.cmd_write_i;
                  wdata_q         <= bus.cmd_wdata_i;
                  bus.reg_addr_o  <= bus.cmd_addr_i;
                  cnt             <= '0;
                  bus.cmd_ready_o <= 1'b0;
                  bus.halt_req_o  <= 1'b1;
                  state           <= HALT;
               end
            end

            HALT: begin
               // a halt seen on the last allowed cycle still wins over the timeout
               if (bus.halted_i) begin
                  if (wr_q) begin
                     bus.reg_we_o    <= 1'b1;
                     bus.reg_wdata_o <= wdata_q;
                     state           <= WRITE;
                  end else begin
                     state <= READ;
                  end
               end else if (cnt == CNT_W'(HALT_TIMEOUT - 1)) begin
                  bus.resp_valid_o <= 1'b1;
                  bus.resp_rdata_o <= '0;
                  bus.resp_err_o   <= 1'b1;
                  state            <= RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            WRITE: begin
               bus.reg_we_o    <= 1'b0;
               bus.reg_wdata_o <= '0;
               if (VERIFY_WR) begin
                  state <= VERIFY;
               end else begin
                  bus.resp_valid_o <= 1'b1;
                  bus.resp_rdata_o <= '0;
                  bus.resp_err_o   <= 1'b0;
                  state            <= RESP;
               end
            end

            VERIFY: begin
               // x0 discards writes, so its readback can never match and is not an error
               bus.resp_valid_o <= 1'b1;
               bus.resp_rdata_o <= bus.reg_rdata_i;
               bus.resp_err_o   <= (bus.reg_addr_o != ADDR_W'(0)) && (bus.reg_rdata_i != wdata_q);
               state            <= RESP;
            end

            READ: begin
               bus.resp_valid_o <= 1'b1;
               bus.resp_rdata_o <= bus.reg_rdata_i;
               bus.resp_err_o   <= 1'b0;
               state            <= RESP;
            end

            RESP: begin
               if (bus.resp_ready_i) begin
                  bus.resp_valid_o <= 1'b0;
                  bus.resp_rdata_o <= '0;
                  bus.resp_err_o   <= 1'b0;
                  bus.halt_req_o   <= 1'b0;
                  bus.reg_addr_o   <= '0;
                  bus.cmd_ready_o  <= 1'b1;
                  state            <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_reg_master.sv
// tb_jtag_reg_master: directed commands against a behavioural register-file and response model.
module tb_jtag_reg_master;

   localparam int unsigned TMO = 4;

   logic clk;
   logic rst;

   jtag_reg_master_if bus ();

   jtag_reg_master #(
      .HALT_TIMEOUT(TMO),
      .VERIFY_WR   (1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // clock generator, 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- environment register file ----------------
   logic [31:0] rf [32];
   logic        rf_init;
   logic        blk_env;

   function automatic logic [31:0] init_val(input int i);
      if (i == 5) return 32'hDEADBEEF;
      return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
   endfunction

   // register file storage; blk_env models a write port that silently loses writes
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
      end else if (bus.reg_we_o && !blk_env) begin
         rf[bus.reg_addr_o] <= bus.reg_wdata_o;
      end
   end

   assign bus.reg_rdata_i = (bus.reg_addr_o == 5'd0) ? 32'd0 : rf[bus.reg_addr_o];

   // ---------------- model and checking state ----------------
   logic [31:0] model_rf [32];
   int          n_chk = 0;
   int          n_err = 0;
   bit          chk_en;
   logic        e_ready, e_halt, e_we, e_valid, e_err;
   logic [4:0]  e_addr;
   logic [31:0] e_wdata, e_rdata;
   logic [31:0] last_rdata;
   logic        last_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_zero();
      e_ready = 1'b0; e_halt = 1'b0; e_we = 1'b0; e_addr = 5'd0;
      e_wdata = 32'd0; e_valid = 1'b0; e_rdata = 32'd0; e_err = 1'b0;
   endtask

   task automatic set_idle();
      set_zero();
      e_ready = 1'b1;
   endtask

   // per-cycle comparison of every meaningful output, mid-cycle
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmd_ready", 32'(bus.cmd_ready_o), 32'(e_ready));
         chk("halt_req", 32'(bus.halt_req_o), 32'(e_halt));
         chk("reg_we", 32'(bus.reg_we_o), 32'(e_we));
         chk("reg_addr", 32'(bus.reg_addr_o), 32'(e_addr));
         chk("resp_valid", 32'(bus.resp_valid_o), 32'(e_valid));
         if (e_we) chk("reg_wdata", bus.reg_wdata_o, e_wdata);
         if (e_valid) begin
            chk("resp_rdata", bus.resp_rdata_o, e_rdata);
            chk("resp_err", 32'(bus.resp_err_o), 32'(e_err));
         end
         if (bus.resp_valid_o && bus.resp_ready_i) begin
            last_rdata = bus.resp_rdata_o;
            last_err   = bus.resp_err_o;
         end
      end
   end

   // one command: hd = cycles halted_i stays low after accept, rdly = cycles resp_ready held low,
   // drop = halted_i falls once the halt is granted, blk = regfile loses the write
   task automatic run_cmd(input bit wr, input logic [4:0] a, input logic [31:0] d,
                          input int hd, input int rdly, input bit drop, input bit blk,
                          output int lat);
      bit          to;
      int          h_cyc, r_cyc, we_cyc;
      logic [31:0] rdv, rb;
      logic        er;
      to     = (hd >= int'(TMO));
      h_cyc  = to ? int'(TMO) : hd + 1;
      r_cyc  = to ? h_cyc + 1 : (wr ? h_cyc + 3 : h_cyc + 2);
      we_cyc = (wr && !to) ? h_cyc + 1 : -1;
      if (to) begin
         rdv = 32'd0; er = 1'b1;
      end else if (!wr) begin
         rdv = model_rf[a]; er = 1'b0;
      end else begin
         rb  = (a == 5'd0) ? 32'd0 : (blk ? model_rf[a] : d);
         rdv = rb;
         er  = (a != 5'd0) && (rb != d);
         if (!blk && a != 5'd0) model_rf[a] = d;
      end
      lat = 0;
      blk_env          = blk;
      bus.cmd_valid_i  = 1'b1;
      bus.cmd_write_i  = wr;
      bus.cmd_addr_i   = a;
      bus.cmd_wdata_i  = d;
      bus.resp_ready_i = 1'b0;
      bus.halted_i     = (hd == 0);
      for (int c = 1; c <= r_cyc + rdly; c++) begin
         @(posedge clk); #1;
         bus.cmd_valid_i  = 1'b1;
         bus.cmd_write_i  = 1'($urandom);
         bus.cmd_addr_i   = 5'($urandom);
         bus.cmd_wdata_i  = $urandom;
         bus.halted_i     = (c > hd) && !(drop && c > hd + 1);
         bus.resp_ready_i = (c >= r_cyc + rdly);
         e_ready = 1'b0; e_halt = 1'b1; e_addr = a;
         e_we    = (c == we_cyc); e_wdata = d;
         e_valid = (c >= r_cyc); e_rdata = rdv; e_err = er;
         if (lat == 0 && bus.resp_valid_o) lat = c;
      end
      @(posedge clk); #1;
      bus.cmd_valid_i  = 1'b0;
      bus.resp_ready_i = 1'b0;
      bus.halted_i     = 1'b0;
      blk_env          = 1'b0;
      set_idle();
   endtask

   // write to x9 interrupted by reset in cycle at_c after accept (2 = WRITE, 3 = VERIFY)
   task automatic rst_mid(input int at_c, input logic [31:0] d);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = 1'b1;
      bus.cmd_addr_i  = 5'd9;
      bus.cmd_wdata_i = d;
      bus.halted_i    = 1'b1;
      for (int c = 1; c <= at_c; c++) begin
         @(posedge clk); #1;
         bus.cmd_addr_i  = 5'($urandom);
         bus.cmd_wdata_i = $urandom;
         e_ready = 1'b0; e_halt = 1'b1; e_addr = 5'd9;
         e_we = (c == 2); e_wdata = d; e_valid = 1'b0;
      end
      #2;
      rst = 1'b1;
      set_zero();
      #1;
      chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
      chk("rst_halt_req", 32'(bus.halt_req_o), 32'd0);
      chk("rst_reg_we", 32'(bus.reg_we_o), 32'd0);
      chk("rst_reg_addr", 32'(bus.reg_addr_o), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
      bus.cmd_valid_i = 1'b0;
      bus.halted_i    = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      if (at_c == 3) model_rf[9] = d;
      @(posedge clk); #1;
      set_idle();
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      rst              = 1'b1;
      rf_init          = 1'b1;
      blk_env          = 1'b0;
      chk_en           = 1'b0;
      bus.cmd_valid_i  = 1'b0;
      bus.cmd_write_i  = 1'b0;
      bus.cmd_addr_i   = 5'd0;
      bus.cmd_wdata_i  = 32'd0;
      bus.resp_ready_i = 1'b0;
      bus.halted_i     = 1'b0;
      last_rdata       = 32'd0;
      last_err         = 1'b0;
      set_zero();
      for (int i = 0; i < 32; i++) model_rf[i] = (i == 0) ? 32'd0 : init_val(i);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
      chk("reset_halt_req", 32'(bus.halt_req_o), 32'd0);
      chk("reset_resp_valid", 32'(bus.resp_valid_o), 32'd0);
      chk("reset_reg_we", 32'(bus.reg_we_o), 32'd0);
      chk("reset_reg_addr", 32'(bus.reg_addr_o), 32'd0);
      chk("reset_resp_rdata", bus.resp_rdata_o, 32'd0);
      chk("reset_resp_err", 32'(bus.resp_err_o), 32'd0);
      rf_init = 1'b0;
      rst     = 1'b0;
      chk_en  = 1'b1;
      @(posedge clk); #1;
      set_idle();
      @(posedge clk); #1;

      // read x5
      run_cmd(1'b0, 5'd5, 32'd0, 0, 0, 1'b0, 1'b0, lat);
      chk("t1_lat", 32'(lat), 32'd3);
      chk("t1_rdata", last_rdata, 32'hDEADBEEF);
      chk("t1_err", 32'(last_err), 32'd0);

      // write x7 then read it back
      run_cmd(1'b1, 5'd7, 32'h12345678, 0, 0, 1'b0, 1'b0, lat);
      chk("t2_lat", 32'(lat), 32'd4);
      chk("t2_rdata", last_rdata, 32'h12345678);
      chk("t2_err", 32'(last_err), 32'd0);
      run_cmd(1'b0, 5'd7, 32'd0, 0, 0, 1'b0, 1'b0, lat);
      chk("t2_read", last_rdata, 32'h12345678);

      // x0 write is dropped without error, reads as zero
      run_cmd(1'b1, 5'd0, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, lat);
      chk("t3_err", 32'(last_err), 32'd0);
      chk("t3_rdata", last_rdata, 32'd0);
      run_cmd(1'b0, 5'd0, 32'd0, 0, 0, 1'b0, 1'b0, lat);
      chk("t3_read", last_rdata, 32'd0);

      // halt timeout on read and on write; the write must not land
      run_cmd(1'b0, 5'd3, 32'd0, 100, 0, 1'b0, 1'b0, lat);
      chk("t4_lat", 32'(lat), 32'd5);
      chk("t4_err", 32'(last_err), 32'd1);
      chk("t4_rdata", last_rdata, 32'd0);
      run_cmd(1'b1, 5'd8, 32'h55AA55AA, 4, 0, 1'b0, 1'b0, lat);
      chk("t4w_lat", 32'(lat), 32'd5);
      chk("t4w_err", 32'(last_err), 32'd1);
      run_cmd(1'b0, 5'd8, 32'd0, 0, 0, 1'b0, 1'b0, lat);
      chk("t4w_read", last_rdata, 32'h10000808);

      // halt granted on the last cycle before timeout
      run_cmd(1'b0, 5'd5, 32'd0, 3, 0, 1'b0, 1'b0, lat);
      chk("t4b_lat", 32'(lat), 32'd6);
      chk("t4b_err", 32'(last_err), 32'd0);
      chk("t4b_rdata", last_rdata, 32'hDEADBEEF);

      // response back-pressure with new commands offered meanwhile
      run_cmd(1'b0, 5'd7, 32'd0, 0, 10, 1'b0, 1'b0, lat);
      chk("t5_lat", 32'(lat), 32'd3);
      chk("t5_rdata", last_rdata, 32'h12345678);

      // write verify mismatch when the regfile loses the write
      run_cmd(1'b1, 5'd12, 32'hA5A5A5A5, 0, 0, 1'b0, 1'b1, lat);
      chk("t7_err", 32'(last_err), 32'd1);
      chk("t7_rdata", last_rdata, 32'h10000C0C);

      // halted_i drops after grant: access still completes
      run_cmd(1'b0, 5'd7, 32'd0, 1, 0, 1'b1, 1'b0, lat);
      chk("t8_lat", 32'(lat), 32'd4);
      chk("t8_rdata", last_rdata, 32'h12345678);

      // reset in WRITE (no write lands) and in VERIFY (write already landed)
      rst_mid(2, 32'hCAFEF00D);
      run_cmd(1'b0, 5'd9, 32'd0, 0, 0, 1'b0, 1'b0, lat);
      chk("t6a_read", last_rdata, 32'h10000909);
      rst_mid(3, 32'hCAFEF00D);
      run_cmd(1'b0, 5'd9, 32'd0, 0, 0, 1'b0, 1'b0, lat);
      chk("t6b_read", last_rdata, 32'hCAFEF00D);

      // top register, slow ready
      run_cmd(1'b1, 5'd31, 32'h0F0F0F0F, 2, 3, 1'b0, 1'b0, lat);
      chk("t9_lat", 32'(lat), 32'd6);
      chk("t9_rdata", last_rdata, 32'h0F0F0F0F);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   // run-time bound
   initial begin
      #100000;
      n_err++;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule
